mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory between the multicycle MIPS core (port 0) and a second bus master such as a DMA or debug loader (port 1). Each access runs through a small sequencing FSM: select, drive memory for a fixed latency, then acknowledge. The arbiter sits between the requesters and the memory's `adr`/`writedata`/`memwrite`/`readdata` pins. Ties are resolved round-robin by default.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/mem_arb_pick.sv | 17 +
 rtl/mem_arbiter.sv | 67 ++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and port indices for mem_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic CPU_PORT = 1'b0;
   localparam logic DMA_PORT = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the two-port memory arbiter
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [1:0]         req, we, ack;
   logic [1:0][AW-1:0] addr;
   logic [1:0][DW-1:0] wdata;
   logic [DW-1:0]      rdata, mem_wd, mem_rd;
   logic [AW-1:0]      mem_adr;
   logic               mem_we, busy, owner;
   modport master (
      output req, we, addr, wdata, mem_rd,
      input  ack, rdata, mem_adr, mem_wd, mem_we, busy, owner
   );
   modport slave (
      input  req, we, addr, wdata, mem_rd,
      output ack, rdata, mem_adr, mem_wd, mem_we, busy, owner
   );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way winner select; MEM_ARBITER_FIXED_PRIO_EN selects fixed port-0 priority
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
`ifndef MEM_ARBITER_FIXED_PRIO_EN
   input  logic       last,
`endif
   output logic       win
);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
   assign win = req[CPU_PORT] ? CPU_PORT : DMA_PORT;
`else
   // on a tie the port not granted last wins
   assign win = &req ? ~last : req[DMA_PORT];
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between CPU (port 0) and a second master via IDLE/ACCESS/DONE FSM
// MEM_ARBITER_FIXED_PRIO_EN: port 0 always wins ties; default is round-robin
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LAT + 1);
   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          wr, win, grant;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
   mem_arb_pick u_pick (.req(bus.req), .win(win));
`else
   logic last;
   mem_arb_pick u_pick (.req(bus.req), .last(last), .win(win));
`endif
   always_comb begin
      grant     = state == IDLE && |bus.req;
      win_addr  = bus.addr[win];
      win_wdata = bus.wdata[win];
      state_nxt = grant ? ACCESS : state == ACCESS ? (cnt == '0 ? DONE : ACCESS) : IDLE;
      bus.ack   = state == DONE ? (bus.owner ? 2'b10 : 2'b01) : 2'b00;
      bus.busy  = state != IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   // mem_we is registered so it is high only in the first ACCESS cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.mem_adr <= '0;
         bus.mem_wd  <= '0;
         bus.mem_we  <= 1'b0;
         bus.rdata   <= '0;
         bus.owner   <= CPU_PORT;
         wr          <= 1'b0;
         cnt         <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
         last        <= DMA_PORT;
`endif
      end else begin
         bus.mem_we <= 1'b0;
         if (grant) begin
            bus.owner   <= win;
            bus.mem_adr <= win_addr;
            bus.mem_wd  <= win_wdata;
            bus.mem_we  <= bus.we[win];
            wr          <= bus.we[win];
            cnt         <= CW'(MEM_LAT - 1);
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last        <= win;
`endif
         end else if (state == ACCESS) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0 && !wr) bus.rdata <= bus.mem_rd;
         end
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_mem_arbiter;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   typedef struct {logic port; logic wr; logic [31:0] d;} ack_t;
   typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
   logic clk = 1'b0, reset = 1'b1;
   int   total = 0, bad = 0, we_n = 0;
   ack_t aq[$];
   wr_t  wq[$];
   ack_t am;
   wr_t  wm;
   mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
   mem_arbiter_if #(.AW(32), .DW(32)) b3 ();
   mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
   mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return a == 32'h40 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction
   assign b1.mem_rd = mem_model(b1.mem_adr);
   assign b3.mem_rd = mem_model(b3.mem_adr);
   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic push_rd(input logic p, input logic [31:0] a);
      aq.push_back('{p, 1'b0, mem_model(a)});
   endtask
   always @(negedge clk) begin
      if (!reset) begin
         if (b1.mem_we) begin
            we_n++;
            if (wq.size() == 0) chk("stray mem_we", 1, 0);
            else begin
               wm = wq.pop_front();
               chk("wr mem_adr", b1.mem_adr, wm.a);
               chk("wr mem_wd", b1.mem_wd, wm.d);
            end
         end
         if (b1.ack != 2'b00) begin
            if (aq.size() == 0) chk("spurious ack", b1.ack, 0);
            else begin
               am = aq.pop_front();
               chk("ack port", b1.ack, am.port ? 2'b10 : 2'b01);
               if (!am.wr) chk("ack rdata", b1.rdata, am.d);
            end
         end
      end
   end
   initial begin
      int   c, k, w0;
      logic p;
      b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
      b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst ack", b1.ack, 0);
      chk("rst rdata", b1.rdata, 0);
      chk("rst mem_adr", b1.mem_adr, 0);
      chk("rst mem_wd", b1.mem_wd, 0);
      chk("rst mem_we", b1.mem_we, 0);
      chk("rst busy", b1.busy, 0);
      chk("rst owner", b1.owner, 0);
      chk("rst busy3", b3.busy, 0);
      // port 0 read, MEM_LAT=1
      b1.req = 2'b01; b1.we = 2'b00; b1.addr[0] = 32'h40;
      push_rd(1'b0, 32'h40);
      @(negedge clk);
      chk("rd mem_adr", b1.mem_adr, 32'h40);
      chk("rd busy", b1.busy, 1);
      chk("rd ack early", b1.ack, 0);
      @(negedge clk);
      chk("rd ack", b1.ack, 2'b01);
      chk("rd rdata", b1.rdata, 32'hDEADBEEF);
      b1.req = 2'b00;
      w0 = we_n;
      @(negedge clk);
      chk("idle busy", b1.busy, 0);
      // port 1 write
      b1.req = 2'b10; b1.we = 2'b10; b1.addr[1] = 32'h80; b1.wdata[1] = 32'h12345678;
      aq.push_back('{1'b1, 1'b1, 32'h0});
      wq.push_back('{32'h80, 32'h12345678});
      @(negedge clk);
      chk("wr we", b1.mem_we, 1);
      chk("wr adr", b1.mem_adr, 32'h80);
      chk("wr wd", b1.mem_wd, 32'h12345678);
      chk("wr owner", b1.owner, 1);
      @(negedge clk);
      chk("wr ack", b1.ack, 2'b10);
      chk("wr we off", b1.mem_we, 0);
      chk("rdata hold", b1.rdata, 32'hDEADBEEF);
      b1.req = 2'b00; b1.we = 2'b00;
      @(posedge clk);
      chk("wr we cycles", we_n - w0, 1);
      // both ports request continuously for 4 transfers
      @(negedge clk);
      b1.req = 2'b11; b1.addr[0] = 32'h100; b1.addr[1] = 32'h200;
      for (int i = 0; i < 4; i++) begin
         p = FIXED ? 1'b0 : i[0];
         push_rd(p, p ? 32'h200 : 32'h100);
      end
      c = 0; k = 0;
      while (k < 4 && c < 40) begin
         @(negedge clk);
         c++;
         if (b1.ack != 2'b00) k++;
      end
      chk("rr acks", k, 4);
      chk("rr span", c, 11);
      b1.req = 2'b00;
      // MEM_LAT=3 read with a back-to-back repeat
      @(negedge clk);
      b3.req = 2'b01; b3.addr[0] = 32'h300;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("lat3 ack", b3.ack, (i == 4 || i == 9) ? 2'b01 : 2'b00);
         chk("lat3 we", b3.mem_we, 0);
         if (i <= 3 || (i >= 6 && i <= 8)) chk("lat3 adr", b3.mem_adr, 32'h300);
         if (i == 4 || i == 9) chk("lat3 rdata", b3.rdata, mem_model(32'h300));
         if (i == 5) chk("lat3 idle", b3.busy, 0);
      end
      b3.req = 2'b00;
      // reset during a write access
      @(negedge clk);
      b1.req = 2'b01; b1.we = 2'b01; b1.addr[0] = 32'h50; b1.wdata[0] = 32'hCAFE0001;
      wq.push_back('{32'h50, 32'hCAFE0001});
      @(negedge clk);
      chk("abort we", b1.mem_we, 1);
      #2 reset = 1'b1;
      #1;
      chk("abort we drop", b1.mem_we, 0);
      chk("abort busy", b1.busy, 0);
      chk("abort ack", b1.ack, 0);
      b1.req = 2'b00; b1.we = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      // tie after reset: pointer must favour port 0 again
      @(negedge clk);
      b1.req = 2'b11; b1.addr[0] = 32'h44; b1.addr[1] = 32'h84;
      push_rd(1'b0, 32'h44);
      push_rd(1'b1, 32'h84);
      c = 0; k = 0;
      while (k < 2 && c < 20) begin
         @(negedge clk);
         c++;
         if (b1.ack != 2'b00) begin
            k++;
            if (k == 1) chk("post-reset first", b1.ack, 2'b01);
            b1.req[0] = 1'b0;
         end
      end
      chk("post-reset acks", k, 2);
      b1.req = 2'b00;
      repeat (3) @(negedge clk);
      chk("ack queue empty", aq.size(), 0);
      chk("write queue empty", wq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
